// File: rtl/nes_pkg.sv
// Shared NES bus constants and the DMA state encoding used by the OAM DMA,
// bus arbiter and APU DMA blocks.
package nes_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/nes_oam_dma.sv
// OAM DMA: snoops CPU writes to $4014, halts the CPU and copies one 256-byte
// page into PPU OAM via $2004 using get/put-aligned read/write cycle pairs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a CPU write to the trigger register
// S_HALT  | CPU halted, waiting for it to reach a read cycle
// S_ALIGN | one dummy cycle so that every READ lands on a get cycle
// S_READ  | DMA reads {page, idx} from the bus
// S_WRITE | DMA writes the fetched byte to OAMDATA, advances idx
module nes_oam_dma
  import nes_pkg::dma_state_t;
  import nes_pkg::S_IDLE;
  import nes_pkg::S_HALT;
  import nes_pkg::S_ALIGN;
  import nes_pkg::S_READ;
  import nes_pkg::S_WRITE;
#(
  parameter logic [15:0] DMA_REG_ADDR = nes_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = nes_pkg::OAMDATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_din,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_rw
);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data;
  logic        parity;
  logic        trigger;

  assign trigger = !cpu_rw && (cpu_addr == DMA_REG_ADDR);

  // parity: 0 = get cycle, 1 = put cycle; runs regardless of DMA activity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
      data   <= 8'h00;
    end else begin
      parity <= ~parity;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            page  <= cpu_dout;
            idx   <= 8'h00;
            state <= S_HALT;
          end
        end
        S_HALT: begin
          // a 6502 write cycle cannot be stalled, so wait for a read
          if (cpu_rw) state <= parity ? S_READ : S_ALIGN;
        end
        S_ALIGN: state <= S_READ;
        S_READ: begin
          data  <= bus_din;
          state <= S_WRITE;
        end
        S_WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? S_IDLE : S_READ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // outputs depend on registered state only
  always_comb begin
    cpu_halt   = (state != S_IDLE);
    dma_active = 1'b0;
    dma_addr   = 16'h0000;
    dma_dout   = 8'h00;
    dma_rw     = 1'b1;
    case (state)
      S_READ: begin
        dma_active = 1'b1;
        dma_addr   = {page, idx};
      end
      S_WRITE: begin
        dma_active = 1'b1;
        dma_addr   = OAMDATA_ADDR;
        dma_dout   = data;
        dma_rw     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: a table of DMA scenarios plus hand-written
// reset and ignored-traffic sequences.
module tb_nes_oam_dma;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic [7:0]  bus_din;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rw;

  int n_checks = 0;
  int n_fail   = 0;
  bit tb_par   = 1'b0;

  nes_oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_rw     (cpu_rw),
    .bus_din    (bus_din),
    .cpu_halt   (cpu_halt),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_rw     (dma_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: every location returns its low address byte xor A5
  always_comb bus_din = dma_active ? (dma_addr[7:0] ^ 8'hA5) : 8'hEE;

  typedef struct {
    logic [7:0] page;
    bit         halt_par;
    int         stall;
    int         inj;
    int         abort;
    int         exp_halt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cpu_addr = 16'h8000;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h00;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    tb_par = ~tb_par;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_halt"},   {31'd0, cpu_halt},   32'd0);
    check({tag, "_active"}, {31'd0, dma_active}, 32'd0);
    check({tag, "_addr"},   {16'd0, dma_addr},   32'd0);
    check({tag, "_dout"},   {24'd0, dma_dout},   32'd0);
    check({tag, "_rw"},     {31'd0, dma_rw},     32'd1);
  endtask

  // async reset asserted mid-cycle; returns at posedge+1 of the first post-reset cycle
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_par = 1'b0;
    idle_inputs();
  endtask

  task automatic run_dma(input vec_t v);
    int  n;
    int  rd;
    int  wr;
    int  first_act;
    bit  last_rd;
    bit  done;
    while (tb_par != !v.halt_par) begin
      idle_inputs();
      next_cycle();
    end
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_dout = v.page;
    @(negedge clk);
    check("trig_cycle_halt", {31'd0, cpu_halt}, 32'd0);
    next_cycle();
    rd = 0; wr = 0; first_act = -1; last_rd = 1'b0; done = 1'b0;
    for (n = 0; n < 700; n++) begin
      if (n < v.stall) begin
        cpu_addr = 16'h0300; cpu_rw = 1'b0; cpu_dout = 8'h5A;
      end else if (n == v.inj) begin
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h33;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (!cpu_halt) begin
        done = 1'b1;
        break;
      end
      if (dma_active && first_act < 0) first_act = n;
      if (dma_active && dma_rw) begin
        check("rd_addr", {16'd0, dma_addr}, {16'd0, v.page, rd[7:0]});
        check("rd_parity", {31'd0, tb_par}, 32'd0);
        check("rd_after_wr", {31'd0, last_rd}, 32'd0);
        rd++;
        last_rd = 1'b1;
      end else if (dma_active) begin
        check("wr_addr", {16'd0, dma_addr}, 32'h2004);
        check("wr_data", {24'd0, dma_dout}, {24'd0, rd[7:0] - 8'd1 ^ 8'hA5});
        check("wr_after_rd", {31'd0, last_rd}, 32'd1);
        wr++;
        last_rd = 1'b0;
        if (v.abort >= 0 && wr - 1 == v.abort) begin
          async_reset("abort");
          return;
        end
      end
      next_cycle();
    end
    if (!done) begin
      check("halt_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    check("halt_cycles", n, v.exp_halt);
    check("first_bus_cycle", first_act, v.exp_halt - 512);
    check("read_count", rd, 32'd256);
    check("write_count", wr, 32'd256);
    check("release_active", {31'd0, dma_active}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("post_release_halt", {31'd0, cpu_halt}, 32'd0);
    next_cycle();
  endtask

  initial begin
    vec_t rv;
    rst = 1'b0;
    idle_inputs();
    // page, halt parity, stall, inject cycle, abort idx, expected halt cycles
    vecs[0] = '{8'h02, 1'b1, 0,  -1, -1, 513};
    vecs[1] = '{8'h02, 1'b0, 0,  -1, -1, 514};
    vecs[2] = '{8'h02, 1'b1, 2,  -1, -1, 515};
    vecs[3] = '{8'hFF, 1'b1, 0, 200, -1, 513};
    vecs[4] = '{8'h10, 1'b0, 1, 513, -1, 514};
    vecs[5] = '{8'h80, 1'b1, 1,  -1, -1, 515};
    vecs[6] = '{8'h03, 1'b1, 0,  -1, 100, 513};

    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_par = 1'b0;

    // non-trigger traffic must not start a DMA
    cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_dout = 8'h07;
    @(negedge clk); check("ign_4015", {31'd0, cpu_halt}, 32'd0); next_cycle();
    cpu_addr = 16'h4014; cpu_rw = 1'b1;
    @(negedge clk); check("ign_rd4014", {31'd0, cpu_halt}, 32'd0); next_cycle();
    cpu_addr = 16'h2004; cpu_rw = 1'b0;
    @(negedge clk); check("ign_2004", {31'd0, cpu_halt}, 32'd0); next_cycle();
    idle_inputs();
    @(negedge clk); check("ign_after", {31'd0, cpu_halt}, 32'd0); next_cycle();

    for (int i = 0; i < 7; i++) run_dma(vecs[i]);

    // restart right after the mid-transfer reset: parity is 0, so HALT is a put cycle
    rv = '{8'h03, 1'b1, 0, -1, -1, 513};
    check("restart_parity", {31'd0, tb_par}, 32'd0);
    run_dma(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nes_oam_dma.md
# nes_oam_dma

OAM DMA controller that sits directly beside `CPU_6502` on the CPU bus. It snoops CPU writes to `$4014`, halts the CPU, and then takes the bus to copy one 256-byte CPU page into PPU OAM through `$2004`. It uses one read/write cycle pair per byte and keeps NES get/put cycle alignment. The top level muxes `dma_addr`, `dma_dout` and `dma_rw` onto the shared bus while `dma_active` is high.

## Interface
- `DMA_REG_ADDR`, default `16'h4014`: trigger register address.
- `OAMDATA_ADDR`, default `16'h2004`: PPU OAM data port.
- `clk` in 1: system clock, one CPU cycle per edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cpu_addr` in 16: CPU address bus.
- `cpu_dout` in 8: CPU write data.
- `cpu_rw` in 1: CPU R/W (1 = read, 0 = write).
- `bus_din` in 8: shared data bus read value. It is valid in the same cycle as the address.
- `cpu_halt` out 1: stalls the CPU (RDY low equivalent).
- `dma_active` out 1: DMA owns the address/data/RW lines.
- `dma_addr` out 16: DMA address.
- `dma_dout` out 8: DMA write data.
- `dma_rw` out 1: DMA R/W (1 = read).

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Registers:
  - `page[7:0]`
  - `idx[7:0]`
  - `data[7:0]`
  - `parity`: free-running, toggles every clock; 0 = get cycle, 1 = put cycle.
- IDLE:
  - A cycle with `cpu_rw==0 && cpu_addr==DMA_REG_ADDR` latches `page<=cpu_dout` and `idx<=0`, then moves to HALT.
  - All other traffic is ignored.
- HALT:
  - `cpu_halt=1`, `dma_active=0`.
  - While `cpu_rw==0`, stay in HALT. The 6502 cannot stall on a write.
  - When `cpu_rw==1`: if `parity==1`, go to READ; otherwise go to ALIGN.
- ALIGN:
  - One dummy cycle with `cpu_halt=1`, `dma_active=0`.
  - Always goes to READ, so every READ lands on `parity==0`.
- READ:
  - Drives `dma_addr={page,idx}`, `dma_rw=1`, `dma_active=1`.
  - `data<=bus_din` at the closing edge, then go to WRITE.
- WRITE:
  - Drives `dma_addr=OAMDATA_ADDR`, `dma_rw=0`, `dma_dout=data`, `dma_active=1`.
  - `idx<=idx+1` with 8-bit wrap.
  - If `idx==8'hFF`, go to IDLE; otherwise go to READ.
- `cpu_halt` is 1 in every state except IDLE.
- Writes to `DMA_REG_ADDR` while not in IDLE are ignored. No retrigger and no queueing.
- Outputs decode from registered state only. There is no combinational path from any input to any output.
- In non-DMA cycles: `dma_addr=16'h0000`, `dma_rw=1`, `dma_dout=8'h00`.

## Timing
- Reset values:
  - state IDLE, `parity=0`, `page=idx=data=0`.
  - `cpu_halt=0`, `dma_active=0`, `dma_addr=0`, `dma_dout=0`, `dma_rw=1`.
- The first cycle after `rst` deasserts has `parity=0`.
- Trigger-to-halt latency: `cpu_halt` rises in the cycle after the trigger write.
- Halt duration, when the HALT cycle sees `cpu_rw==1` immediately:
  - 513 cycles if the HALT cycle has parity 1.
  - 514 cycles if it has parity 0 (ALIGN inserted).
  - Each extra cycle spent in HALT with `cpu_rw==0` adds 1.
- Transfer: 512 cycles of strictly alternating READ/WRITE. No gaps, no back-pressure.
- After the final WRITE (`idx` 0xFF, addr `$2004`), `cpu_halt` and `dma_active` are 0 in the next cycle.
- Page wrap: `idx` wraps within the page. Page `0xFF` reads `$FF00..$FFFF` and never carries into `page`.
- Reset mid-transfer: asynchronous return to reset values. The partial OAM contents are left as they are, and the CPU is released immediately.
- A trigger write in the same cycle that an in-progress DMA finishes (WRITE, `idx==FF`) is ignored.

## Structure
- `nes_pkg` holds:
  - `DMA_REG_ADDR`
  - `OAMDATA_ADDR`
  - the `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE), shared with the future bus-arbiter and APU-DMA blocks.
- Single module with no sub-modules. The parity flop and the index counter are inline.

## Test plan
- **Reset:** assert `rst` mid-cycle, asynchronously → all outputs at reset values at once; `parity=0` in the first post-reset cycle.
- **Basic copy:**
  - Stimulus: memory model returns `addr[7:0]^8'hA5`; write `8'h02` to `$4014`; HALT cycle has parity 1.
  - Response: `cpu_halt` high for exactly 513 cycles.
  - Response: 256 READs of `$0200..$02FF`, each followed by a write of `idx^8'hA5` to `$2004`, in order.
- **Alignment:** same trigger, but the HALT cycle has parity 0 → exactly one ALIGN cycle; 514 halt cycles; every READ at `parity=0`.
- **Write-stall:** hold `cpu_rw=0` for 2 cycles after the trigger → HALT lasts 3 cycles; no bus drive (`dma_active=0`) until READ.
- **Page FF and retrigger:**
  - Trigger page `8'hFF` → reads `$FF00..$FFFF` and `page` stays `FF`.
  - A `$4014` write injected mid-DMA (top model keeps driving `cpu_addr`/`cpu_rw`) → ignored; transfer count stays 256.
- **Reset at byte 100:** assert `rst` during the WRITE of idx 100 → `cpu_halt`/`dma_active` drop immediately; a new trigger after release restarts from idx 0.
